// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-side arbiter.
package fifo_arb_pkg;

  // Default beat width and depth of the FIFO this arbiter feeds.
  localparam int DATA_W_DEF = 32;
  localparam int FIFO_DEPTH = 256;

  // Arbiter FSM: IDLE holds no grant, XFER holds a grant for one packet or burst.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  // Width of a requester index. Kept at least 1 bit so that N=2 still gets a real vector.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of a counter that has to hold values 0..max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: finds the first set valid bit at or after rr_ptr,
// wrapping modulo N_REQ. Purely combinational.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  localparam logic [IDX_W:0] N_EXT = (IDX_W + 1)'(N_REQ);

  // Candidate gi is the requester sitting gi places after rr_ptr.
  logic [IDX_W:0]   sum        [N_REQ];
  logic [IDX_W-1:0] cand       [N_REQ];
  logic [N_REQ-1:0] cand_valid;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      // rr_ptr is always below N_REQ, so one conditional subtract wraps it.
      assign sum[gi]        = {1'b0, rr_ptr} + (IDX_W + 1)'(gi);
      assign cand[gi]       = (sum[gi] >= N_EXT) ? IDX_W'(sum[gi] - N_EXT)
                                                 : sum[gi][IDX_W-1:0];
      assign cand_valid[gi] = valid[cand[gi]];
    end
  endgenerate

  // Priority select: scanning downward leaves the smallest offset as the winner.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand_valid[k]) begin
        found = 1'b1;
        idx   = cand[k];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter feeding a single FIFO write port from N_REQ
// packet producers. A grant is held for a whole packet, capped at MAX_BURST
// beats, and is revoked if the grantee stalls for IDLE_TIMEOUT cycles.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_data,
  input  logic                      fifo_wr_full,
  output logic [idx_w(N_REQ)-1:0]   grant_id,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int IDX_W  = idx_w(N_REQ);
  localparam int BEAT_W = cnt_w(MAX_BURST);
  localparam int IDLE_W = cnt_w(IDLE_TIMEOUT);

  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BURST);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_REQ - 1);

  arb_state_t        state_reg,    state_next;
  logic [IDX_W-1:0]  grant_id_reg, grant_id_next;
  logic [IDX_W-1:0]  rr_ptr_reg,   rr_ptr_next;
  logic [BEAT_W-1:0] beat_cnt_reg, beat_cnt_next;
  logic [IDLE_W-1:0] idle_cnt_reg, idle_cnt_next;

  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  logic              xfer;
  logic              grant_valid;
  logic              grant_last;
  logic              handshake;
  logic [BEAT_W-1:0] beat_cnt_inc;
  logic [IDLE_W-1:0] idle_cnt_inc;
  logic [IDX_W-1:0]  rr_after_grant;
  logic [DATA_W-1:0] req_slice [N_REQ];

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .valid  (req_valid),
    .rr_ptr (rr_ptr_reg),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  assign xfer        = (state_reg == XFER);
  assign grant_valid = req_valid[grant_id_reg];
  assign grant_last  = req_last[grant_id_reg];

  // Ready follows full in the same cycle, so a write is never issued into a full FIFO.
  assign handshake    = xfer && grant_valid && !fifo_wr_full;
  assign beat_cnt_inc = beat_cnt_reg + BEAT_W'(1);
  assign idle_cnt_inc = idle_cnt_reg + IDLE_W'(1);

  // Next round-robin start once the current grantee gives up the grant.
  assign rr_after_grant = (grant_id_reg == LAST_IDX) ? '0 : grant_id_reg + IDX_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign req_slice[gi] = req_data[gi*DATA_W +: DATA_W];
      assign req_ready[gi] = xfer && (grant_id_reg == IDX_W'(gi)) && !fifo_wr_full;
    end
  endgenerate

  // Write port is a straight pass-through of the grantee; data is zeroed outside a grant.
  assign fifo_wr_en   = handshake;
  assign fifo_wr_data = xfer ? req_slice[grant_id_reg] : '0;
  assign grant_id     = grant_id_reg;
  assign busy         = xfer;

  // Fires in the cycle that completes the last idle cycle allowed, i.e. the cycle the grant is dropped.
  assign timeout_err  = xfer && !grant_valid && (idle_cnt_inc == IDLE_MAX);

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      grant_id_reg <= '0;
      rr_ptr_reg   <= '0;
      beat_cnt_reg <= '0;
      idle_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      grant_id_reg <= grant_id_next;
      rr_ptr_reg   <= rr_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
      idle_cnt_reg <= idle_cnt_next;
    end
  end

  // Grant / release decisions and counter updates.
  always_comb begin
    state_next    = state_reg;
    grant_id_next = grant_id_reg;
    rr_ptr_next   = rr_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    idle_cnt_next = idle_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next    = XFER;
          grant_id_next = pick_idx;
          beat_cnt_next = '0;
          idle_cnt_next = '0;
        end
      end

      XFER: begin
        if (handshake) begin
          beat_cnt_next = beat_cnt_inc;
          idle_cnt_next = '0;
          // End of packet wins over the burst cap; both release the same way.
          if (grant_last || (beat_cnt_inc == BEAT_MAX)) begin
            state_next    = IDLE;
            rr_ptr_next   = rr_after_grant;
            beat_cnt_next = '0;
          end
        end else if (!grant_valid) begin
          // Only a missing beat counts as idle; a beat held back by full does not.
          idle_cnt_next = idle_cnt_inc;
          if (idle_cnt_inc == IDLE_MAX) begin
            state_next    = IDLE;
            rr_ptr_next   = rr_after_grant;
            beat_cnt_next = '0;
            idle_cnt_next = '0;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-requester beat sources, a write log
// of everything that reaches the FIFO port, and hand-computed expectations.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int SRC_DEPTH = 64;
  localparam int LOG_DEPTH = 128;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data  = '0;
  logic [N-1:0]    req_last  = '0;
  logic [N-1:0]    req_ready;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wr_data;
  logic            fifo_wr_full = 1'b0;
  logic [1:0]      grant_id;
  logic            busy;
  logic            timeout_err;

  fifo_wr_arbiter #(
    .N_REQ        (N),
    .DATA_W       (DW),
    .MAX_BURST    (16),
    .IDLE_TIMEOUT (64)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr_full (fifo_wr_full),
    .grant_id     (grant_id),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  // Beat sources, one per requester.
  logic [DW-1:0] src_mem [N][SRC_DEPTH];
  bit            src_lst [N][SRC_DEPTH];
  int            src_len [N];
  int            src_pos [N];
  bit            pause   [N];
  bit            hs_q    [N];
  bit            full_flag = 1'b0;
  bit            rst_flag  = 1'b1;

  // Log of FIFO writes as seen on the write port.
  logic [DW-1:0] wr_data_log [LOG_DEPTH];
  int            wr_cyc      [LOG_DEPTH];
  int            wr_gid      [LOG_DEPTH];
  int            wr_n    = 0;
  int            cycle   = 0;
  int            tmo_cnt = 0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_beat(input int r, input logic [DW-1:0] d, input bit last);
    src_mem[r][src_len[r]] = d;
    src_lst[r][src_len[r]] = last;
    src_len[r]++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (!pause[i] && src_pos[i] < src_len[i]) begin
        req_valid[i]            = 1'b1;
        req_data[i*DW +: DW]    = src_mem[i][src_pos[i]];
        req_last[i]             = src_lst[i][src_pos[i]];
      end else begin
        req_valid[i]            = 1'b0;
        req_data[i*DW +: DW]    = '0;
        req_last[i]             = 1'b0;
      end
    end
    fifo_wr_full = full_flag;
  endtask

  // One clock: inputs change just after the rising edge, outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    rst = rst_flag;
    for (int i = 0; i < N; i++) begin
      if (hs_q[i]) src_pos[i]++;
    end
    drive();
    @(negedge clk);
    cycle++;
    for (int i = 0; i < N; i++) hs_q[i] = req_valid[i] & req_ready[i];
    if (timeout_err) tmo_cnt++;
    if (fifo_wr_en && wr_n < LOG_DEPTH) begin
      wr_data_log[wr_n] = fifo_wr_data;
      wr_cyc[wr_n]      = cycle;
      wr_gid[wr_n]      = int'(grant_id);
      $display("[TB] write %0d: cycle %0d grant %0d data 0x%08h", wr_n, cycle, grant_id, fifo_wr_data);
      wr_n++;
    end
  endtask

  task automatic run_until_writes(input int n, input int budget);
    int b;
    b = 0;
    while (wr_n < n && b < budget) begin
      step();
      b++;
    end
    check_eq($sformatf("write_count_%0d", n), 64'(wr_n), 64'(n));
  endtask

  task automatic clear_sources();
    for (int i = 0; i < N; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
      pause[i]   = 1'b0;
      hs_q[i]    = 1'b0;
    end
    full_flag = 1'b0;
  endtask

  task automatic do_reset();
    rst_flag = 1'b1;
    clear_sources();
    step();
    step();
    check_eq("rst_req_ready",   req_ready,    0);
    check_eq("rst_fifo_wr_en",  fifo_wr_en,   0);
    check_eq("rst_fifo_wr_data", fifo_wr_data, 0);
    check_eq("rst_grant_id",    grant_id,     0);
    check_eq("rst_busy",        busy,         0);
    check_eq("rst_timeout_err", timeout_err,  0);
    rst_flag = 1'b0;
    step();
    wr_n    = 0;
    tmo_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
      pause[i]   = 1'b0;
      hs_q[i]    = 1'b0;
    end

    // Test 1: single 3-beat packet from requester 1, then rr_ptr lands on 2.
    do_reset();
    push_beat(1, 32'hA1, 1'b0);
    push_beat(1, 32'hA2, 1'b0);
    push_beat(1, 32'hA3, 1'b1);
    step();
    check_eq("t1_arb_ready", req_ready, 0);
    check_eq("t1_arb_busy",  busy,      0);
    step();
    check_eq("t1_ready",   req_ready,    4'b0010);
    check_eq("t1_wr_en",   fifo_wr_en,   1);
    check_eq("t1_data0",   fifo_wr_data, 32'hA1);
    check_eq("t1_grant",   grant_id,     1);
    check_eq("t1_busy",    busy,         1);
    step();
    step();
    check_eq("t1_data2",   fifo_wr_data, 32'hA3);
    step();
    check_eq("t1_rel_busy", busy,       0);
    check_eq("t1_rel_wr",   fifo_wr_en, 0);
    check_eq("t1_count",    64'(wr_n),  3);
    check_eq("t1_data1",    wr_data_log[1], 32'hA2);
    check_eq("t1_span",     64'(wr_cyc[2] - wr_cyc[0]), 2);
    // With rr_ptr=2, requester 3 must beat requester 0.
    push_beat(0, 32'hB0, 1'b1);
    push_beat(3, 32'hD0, 1'b1);
    step();
    check_eq("t1_gap_busy", busy, 0);
    step();
    check_eq("t1_rr_grant", grant_id,     3);
    check_eq("t1_rr_data",  fifo_wr_data, 32'hD0);
    run_until_writes(5, 10);
    check_eq("t1_wrap_grant", 64'(wr_gid[4]), 0);
    check_eq("t1_wrap_data",  wr_data_log[4], 32'hB0);

    // Test 2: all requesters always valid with 1-beat packets.
    do_reset();
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 2; k++) push_beat(i, 32'hC000_0000 | (i << 8) | k, 1'b1);
    end
    run_until_writes(5, 40);
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("t2_grant_%0d", k), 64'(wr_gid[k]), 64'(k % 4));
      if (k > 0) check_eq($sformatf("t2_gap_%0d", k), 64'(wr_cyc[k] - wr_cyc[k-1]), 2);
    end
    check_eq("t2_data4", wr_data_log[4], 32'hC000_0001);

    // Test 3: 40-beat packet from requester 0 cut into 16-beat bursts, requester 2 interleaved.
    do_reset();
    for (int k = 0; k < 40; k++) push_beat(0, 32'h100 + k, k == 39);
    for (int k = 0; k < 3; k++)  push_beat(2, 32'h200 + k, k == 2);
    run_until_writes(43, 200);
    for (int k = 0; k < 43; k++) begin
      logic [DW-1:0] exp_d;
      if (k < 16)      exp_d = 32'h100 + k;
      else if (k < 19) exp_d = 32'h200 + (k - 16);
      else             exp_d = 32'h100 + (k - 3);
      check_eq($sformatf("t3_data_%0d", k), wr_data_log[k], exp_d);
    end
    check_eq("t3_burst_span", 64'(wr_cyc[15] - wr_cyc[0]), 15);
    check_eq("t3_gap16",      64'(wr_cyc[16] - wr_cyc[15]), 2);
    check_eq("t3_grant16",    64'(wr_gid[16]), 2);
    check_eq("t3_gap19",      64'(wr_cyc[19] - wr_cyc[18]), 2);
    check_eq("t3_grant19",    64'(wr_gid[19]), 0);
    check_eq("t3_gap35",      64'(wr_cyc[35] - wr_cyc[34]), 2);

    // Test 4: FIFO full for 5 cycles mid-packet, then a long full stall that must not time out.
    do_reset();
    for (int k = 0; k < 8; k++) push_beat(1, 32'h400 + k, k == 7);
    run_until_writes(3, 10);
    full_flag = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq($sformatf("t4_full_ready_%0d", k), req_ready,  0);
      check_eq($sformatf("t4_full_wr_%0d", k),    fifo_wr_en, 0);
      check_eq($sformatf("t4_full_busy_%0d", k),  busy,       1);
    end
    full_flag = 1'b0;
    run_until_writes(8, 20);
    check_eq("t4_gap", 64'(wr_cyc[3] - wr_cyc[2]), 6);
    for (int k = 0; k < 8; k++)
      check_eq($sformatf("t4_data_%0d", k), wr_data_log[k], 32'h400 + k);
    push_beat(1, 32'h410, 1'b0);
    push_beat(1, 32'h411, 1'b1);
    run_until_writes(9, 10);
    full_flag = 1'b1;
    repeat (70) step();
    check_eq("t4_long_busy",  busy,          1);
    check_eq("t4_long_tmo",   64'(tmo_cnt),  0);
    check_eq("t4_long_count", 64'(wr_n),     9);
    full_flag = 1'b0;
    run_until_writes(10, 10);
    check_eq("t4_long_data", wr_data_log[9], 32'h411);

    // Test 5: grantee stops sending mid-packet; grant revoked after 64 idle cycles.
    do_reset();
    for (int k = 0; k < 10; k++) push_beat(1, 32'h500 + k, k == 9);
    push_beat(2, 32'h600, 1'b1);
    run_until_writes(3, 10);
    pause[1] = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      step();
      check_eq($sformatf("t5_tmo_%0d", k),  timeout_err, (k == 64) ? 1 : 0);
      check_eq($sformatf("t5_busy_%0d", k), busy,        1);
    end
    step();
    check_eq("t5_rel_busy", busy,        0);
    check_eq("t5_rel_tmo",  timeout_err, 0);
    step();
    check_eq("t5_next_grant", grant_id,     2);
    check_eq("t5_next_wr",    fifo_wr_en,   1);
    check_eq("t5_next_data",  fifo_wr_data, 32'h600);
    check_eq("t5_tmo_count",  64'(tmo_cnt), 1);

    // Test 6: asynchronous reset while beat 5 is on the write port.
    do_reset();
    for (int k = 0; k < 10; k++) push_beat(2, 32'h700 + k, k == 9);
    run_until_writes(5, 12);
    check_eq("t6_pre_wr", fifo_wr_en, 1);
    #1;
    rst      = 1'b1;
    rst_flag = 1'b1;
    #1;
    check_eq("t6_async_ready", req_ready,    0);
    check_eq("t6_async_wr",    fifo_wr_en,   0);
    check_eq("t6_async_data",  fifo_wr_data, 0);
    check_eq("t6_async_grant", grant_id,     0);
    check_eq("t6_async_busy",  busy,         0);
    check_eq("t6_async_tmo",   timeout_err,  0);
    clear_sources();
    push_beat(1, 32'h810, 1'b1);
    push_beat(3, 32'h830, 1'b1);
    step();
    rst_flag = 1'b0;
    step();
    check_eq("t6_post_busy", busy, 0);
    step();
    check_eq("t6_post_grant", grant_id,     1);
    check_eq("t6_post_wr",    fifo_wr_en,   1);
    check_eq("t6_post_data",  fifo_wr_data, 32'h810);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
